// File: rtl/l1_trigger_ctrl_pkg.sv
// Shared widths and readout FSM encoding
// for the L1 trigger control stage.
package l1_trigger_ctrl_pkg;

  localparam int DEF_PTR_W  = 4;
  localparam int DEF_BC_W   = 8;
  localparam int DEF_LV1_W  = 7;
  localparam int DEF_SKIP_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    BUSY   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/l1_trigger_ctrl_fifo.sv
// Header-store pointer bookkeeping: write/read
// pointers, occupancy and registered full/empty.
module l1_ptr_fifo_ctrl
  import l1_trigger_ctrl_pkg::*;
#(
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W:0]   occupancy,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] DEPTH = {1'b1, {PTR_W{1'b0}}};

  logic [PTR_W:0] occ_next;

  // Occupancy moves only when exactly one of accept/pop happens
  always_comb begin
    occ_next = occupancy;
    if (accept && !pop)
      occ_next = occupancy + (PTR_W+1)'(1);
    else if (pop && !accept)
      occ_next = occupancy - (PTR_W+1)'(1);
  end

  // Pointers wrap naturally; flags come from next-state occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(accept);
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      occupancy <= occ_next;
      full      <= (occ_next == DEPTH);
      empty     <= (occ_next == '0);
    end
  end

endmodule

// File: rtl/l1_trigger_ctrl.sv
// L1 trigger control: bunch/trigger counters,
// header-store pointers and readout handshake.
module l1_trigger_ctrl
  import l1_trigger_ctrl_pkg::*;
#(
  parameter int PTR_W  = DEF_PTR_W,
  parameter int BC_W   = DEF_BC_W,
  parameter int LV1_W  = DEF_LV1_W,
  parameter int SKIP_W = DEF_SKIP_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              L1,
  input  logic              BCR,
  input  logic              ECR,
  input  logic              ReadDone,
  output logic [BC_W-1:0]   BC,
  output logic [LV1_W-1:0]  LV1Id,
  output logic [PTR_W-1:0]  L1In,
  output logic [PTR_W-1:0]  L1Req,
  output logic              L1_Reg_Full,
  output logic              L1_Reg_Empty,
  output logic [PTR_W:0]    Occupancy,
  output logic              ReadReq,
  output logic [SKIP_W-1:0] Skipped
);

  rd_state_e state;
  rd_state_e state_next;
  logic      accept;
  logic      pop;
  logic      drop;

  // Registered full flag gates both the store write and the counters
  assign accept = L1 && !L1_Reg_Full;
  assign drop   = L1 && L1_Reg_Full;

  // Bunch counter: BCR wins over the free-running increment
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      BC <= '0;
    else if (BCR)
      BC <= '0;
    else
      BC <= BC + BC_W'(1);
  end

  // Trigger ID: accepted trigger keeps current ID even under ECR
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      LV1Id <= '0;
    else if (ECR)
      LV1Id <= '0;
    else if (accept)
      LV1Id <= LV1Id + LV1_W'(1);
  end

  // Dropped-trigger count, saturating, cleared by ECR
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Skipped <= '0;
    else if (ECR)
      Skipped <= '0;
    else if (drop && (Skipped != '1))
      Skipped <= Skipped + SKIP_W'(1);
  end

  // Readout FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Readout FSM: settle one cycle on L1Req, then request until done
  always_comb begin
    state_next = state;
    ReadReq    = 1'b0;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!L1_Reg_Empty)
          state_next = SETTLE;
      end
      SETTLE: begin
        state_next = BUSY;
      end
      BUSY: begin
        ReadReq = 1'b1;
        if (ReadDone) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  l1_ptr_fifo_ctrl #(
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .accept    (accept),
    .pop       (pop),
    .wr_ptr    (L1In),
    .rd_ptr    (L1Req),
    .occupancy (Occupancy),
    .full      (L1_Reg_Full),
    .empty     (L1_Reg_Empty)
  );

endmodule

// File: tb/tb_l1_trigger_ctrl.sv
// Directed bench for l1_trigger_ctrl with
// hand-computed expectations.
module tb_l1_trigger_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       L1;
  logic       BCR;
  logic       ECR;
  logic       ReadDone;
  logic [7:0] BC;
  logic [6:0] LV1Id;
  logic [3:0] L1In;
  logic [3:0] L1Req;
  logic       L1_Reg_Full;
  logic       L1_Reg_Empty;
  logic [4:0] Occupancy;
  logic       ReadReq;
  logic [7:0] Skipped;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  l1_trigger_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .L1           (L1),
    .BCR          (BCR),
    .ECR          (ECR),
    .ReadDone     (ReadDone),
    .BC           (BC),
    .LV1Id        (LV1Id),
    .L1In         (L1In),
    .L1Req        (L1Req),
    .L1_Reg_Full  (L1_Reg_Full),
    .L1_Reg_Empty (L1_Reg_Empty),
    .Occupancy    (Occupancy),
    .ReadReq      (ReadReq),
    .Skipped      (Skipped)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    L1       = 1'b0;
    BCR      = 1'b0;
    ECR      = 1'b0;
    ReadDone = 1'b0;
    repeat (2) step();
    check("rst_bc",    BC, 0);
    check("rst_lv1",   LV1Id, 0);
    check("rst_l1in",  L1In, 0);
    check("rst_l1req", L1Req, 0);
    check("rst_occ",   Occupancy, 0);
    check("rst_skip",  Skipped, 0);
    check("rst_req",   ReadReq, 0);
    check("rst_empty", L1_Reg_Empty, 1);
    check("rst_full",  L1_Reg_Full, 0);
    Reset = 1'b0;
    check("bc_c0", BC, 0);

    // free-running BC
    for (int i = 1; i < 300; i++) begin
      step();
      if (i == 1)   check("bc_c1", BC, 1);
      if (i == 255) check("bc_c255", BC, 255);
      if (i == 256) check("bc_wrap", BC, 0);
    end
    check("bc_c299", BC, 43);
    check("idle_l1in",  L1In, 0);
    check("idle_occ",   Occupancy, 0);
    check("idle_empty", L1_Reg_Empty, 1);
    check("idle_req",   ReadReq, 0);
    check("idle_lv1",   LV1Id, 0);

    // BCR at BC=100
    repeat (57) step();
    check("bc_100", BC, 100);
    BCR = 1'b1;
    step();
    BCR = 1'b0;
    check("bcr_0", BC, 0);
    step();
    check("bcr_1", BC, 1);

    // three triggers
    L1 = 1'b1;
    check("t3_id0", LV1Id, 0);
    step();
    check("t3_id1", LV1Id, 1);
    check("t3_req_a", ReadReq, 0);
    step();
    check("t3_id2", LV1Id, 2);
    check("t3_req_b", ReadReq, 0);
    step();
    L1 = 1'b0;
    check("t3_req_c", ReadReq, 1);
    check("t3_l1in", L1In, 3);
    check("t3_occ", Occupancy, 3);
    repeat (4) step();
    check("t3_req_hold", ReadReq, 1);
    check("t3_occ_hold", Occupancy, 3);

    // pop, then ReadDone outside BUSY is ignored
    ReadDone = 1'b1;
    step();
    ReadDone = 1'b0;
    check("pop_l1req", L1Req, 1);
    check("pop_occ", Occupancy, 2);
    check("pop_req", ReadReq, 0);
    ReadDone = 1'b1;
    step();
    step();
    ReadDone = 1'b0;
    check("ign_l1req", L1Req, 1);
    check("ign_occ", Occupancy, 2);
    check("ign_req", ReadReq, 1);

    // fill the store and overflow
    do_reset();
    L1 = 1'b1;
    repeat (16) step();
    check("fill_full", L1_Reg_Full, 1);
    check("fill_l1in", L1In, 0);
    check("fill_occ", Occupancy, 16);
    check("fill_lv1", LV1Id, 16);
    repeat (2) step();
    L1 = 1'b0;
    check("ovf_skip", Skipped, 2);
    check("ovf_l1in", L1In, 0);
    check("ovf_lv1", LV1Id, 16);
    check("ovf_occ", Occupancy, 16);
    check("ovf_req", ReadReq, 1);

    // full: L1 and ReadDone together
    L1       = 1'b1;
    ReadDone = 1'b1;
    step();
    L1       = 1'b0;
    ReadDone = 1'b0;
    check("fp_skip", Skipped, 3);
    check("fp_l1req", L1Req, 1);
    check("fp_occ", Occupancy, 15);
    check("fp_full", L1_Reg_Full, 0);
    check("fp_l1in", L1In, 0);
    step();
    L1 = 1'b1;
    step();
    L1 = 1'b0;
    check("re_l1in", L1In, 1);
    check("re_occ", Occupancy, 16);
    check("re_full", L1_Reg_Full, 1);
    check("re_lv1", LV1Id, 17);
    ECR = 1'b1;
    step();
    ECR = 1'b0;
    check("ecr_skip", Skipped, 0);
    check("ecr_lv1", LV1Id, 0);

    // ECR coincident with an accept
    do_reset();
    L1 = 1'b1;
    repeat (5) step();
    ECR = 1'b1;
    check("ecra_id5", LV1Id, 5);
    step();
    ECR = 1'b0;
    check("ecra_next0", LV1Id, 0);
    step();
    L1 = 1'b0;
    check("ecra_id1", LV1Id, 1);
    check("ecra_l1in", L1In, 7);
    check("ecra_skip", Skipped, 0);

    // async reset with entries pending
    do_reset();
    L1 = 1'b1;
    repeat (4) step();
    L1 = 1'b0;
    repeat (4) step();
    check("pend_occ", Occupancy, 4);
    check("pend_req", ReadReq, 1);
    #3;
    Reset = 1'b1;
    #1;
    check("ar_l1in", L1In, 0);
    check("ar_l1req", L1Req, 0);
    check("ar_empty", L1_Reg_Empty, 1);
    check("ar_req", ReadReq, 0);
    check("ar_occ", Occupancy, 0);
    check("ar_bc", BC, 0);
    step();
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
